// File: rtl/grid_cell_fetch.sv
// -----------------------------------------------------------------------------
// grid_cell_fetch
//
// Video-side reader of the snake board RAM. Follows the raster coming from the
// VGA timing generator, works out which board cell the current pixel falls on
// and issues the board-RAM read for it. The cell type is returned to the colour
// stage together with DE/HS/VS, all delayed by exactly 3 pixel clocks.
//
// Cell coordinates are tracked with incremental counters (sub-cell pixel and
// line counters plus a running row base address), so no divider or multiplier
// is needed.
//
// Optional feature (compile-time macro GRID_GAP_EN):
//   defined   - the first GAP pixels and lines of each cell are background
//               (grid lines); no RAM read is issued on them.
//   undefined - every pixel of every cell is inside; GAP is ignored.
//
// Ports:
//   clk                 in   pixel clock
//   rst_n               in   asynchronous active-low reset
//   de_in, hs_in, vs_in in   active video and syncs (active-high)
//   px, py              in   pixel column / line, valid while de_in=1
//   rd_en               out  board RAM read strobe
//   rd_addr             out  board RAM address row*GRID_W+col (held while idle)
//   rd_data             in   cell type from sync RAM, 1 cycle after rd_en
//   grid_point_inside   out  pixel lies on a cell
//   grid_cell_type      out  cell type, 0 when not inside
//   de_out/hs_out/vs_out out inputs delayed by 3 cycles
// -----------------------------------------------------------------------------
module grid_cell_fetch #(
    parameter int COORD_W   = 11,
    parameter int ADDR_W    = 9,
    parameter int GRID_X0   = 160,
    parameter int GRID_Y0   = 40,
    parameter int CELL_SIZE = 16,
    parameter int GRID_W    = 20,
    parameter int GRID_H    = 25,
    parameter int GAP       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               de_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [2:0]         rd_data,
    output logic               grid_point_inside,
    output logic [2:0]         grid_cell_type,
    output logic               de_out,
    output logic               hs_out,
    output logic               vs_out
);

    localparam int COL_W = $clog2(GRID_W + 1);
    localparam int ROW_W = $clog2(GRID_H + 1);
    localparam int SUB_W = $clog2(CELL_SIZE);

    // Column/row value meaning "outside the grid"; counters saturate here.
    localparam logic [COL_W-1:0]   COL_OUT  = COL_W'(GRID_W);
    localparam logic [ROW_W-1:0]   ROW_OUT  = ROW_W'(GRID_H);
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(CELL_SIZE - 1);
    localparam logic [COORD_W-1:0] X0_PX    = COORD_W'(GRID_X0);
    // Line just above the grid; its end arms the row tracker.
    localparam logic [COORD_W-1:0] Y_PRE    = COORD_W'((GRID_Y0 > 0) ? GRID_Y0 - 1 : 0);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(GRID_W);

    // ------------------------------------------------------------------
    // Raster tracking state
    // ------------------------------------------------------------------
    logic [COL_W-1:0]   col_q, col_d;
    logic [SUB_W-1:0]   sx_q, sx_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [SUB_W-1:0]   sy_q, sy_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               de_q, vs_q;
    logic [COORD_W-1:0] py_last_q, py_last_d;

    logic line_end;
    logic vs_rise;

    assign line_end  = de_q & ~de_in;
    assign vs_rise   = vs_in & ~vs_q;
    // py is only meaningful during active video, so the line number used at
    // the end of a line is the one captured on its last active pixel.
    assign py_last_d = de_in ? py : py_last_q;

    // Column state for the current pixel. It also feeds stage 0 directly, so
    // the inside/address decision uses the column this px belongs to.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no
        // path can leave it unassigned, which would infer a latch.
        col_d = col_q;
        sx_d  = sx_q;
        if (!de_in) begin
            col_d = COL_OUT;
        end else if (px == X0_PX) begin
            col_d = '0;
            sx_d  = '0;
        end else if (col_q < COL_OUT) begin
            if (sx_q == SUB_LAST) begin
                sx_d  = '0;
                col_d = col_q + COL_W'(1);
            end else begin
                sx_d  = sx_q + SUB_W'(1);
            end
        end
    end

    // Row state advances once per line; a vsync rising edge takes priority.
    always_comb begin
        row_d      = row_q;
        sy_d       = sy_q;
        row_base_d = row_base_q;
        if (vs_rise) begin
            if (GRID_Y0 == 0) begin
                row_d      = '0;
                sy_d       = '0;
                row_base_d = '0;
            end else begin
                row_d = ROW_OUT;
            end
        end else if (line_end) begin
            if ((GRID_Y0 != 0) && (py_last_q == Y_PRE)) begin
                row_d      = '0;
                sy_d       = '0;
                row_base_d = '0;
            end else if (row_q < ROW_OUT) begin
                if (sy_q == SUB_LAST) begin
                    sy_d       = '0;
                    row_d      = row_q + ROW_W'(1);
                    row_base_d = row_base_q + ROW_STEP;
                end else begin
                    sy_d = sy_q + SUB_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= COL_OUT;
            sx_q       <= '0;
            row_q      <= ROW_OUT;
            sy_q       <= '0;
            row_base_q <= '0;
            de_q       <= 1'b0;
            vs_q       <= 1'b0;
            py_last_q  <= '0;
        end else begin
            col_q      <= col_d;
            sx_q       <= sx_d;
            row_q      <= row_d;
            sy_q       <= sy_d;
            row_base_q <= row_base_d;
            de_q       <= de_in;
            vs_q       <= vs_in;
            py_last_q  <= py_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: inside decision and address
    // ------------------------------------------------------------------
    logic              gap_ok;
    logic              inside0;
    logic [ADDR_W-1:0] addr0;

`ifdef GRID_GAP_EN
    localparam logic [SUB_W-1:0] GAP_PX = SUB_W'(GAP);
    // Leading pixels/lines of each cell form the grid lines.
    assign gap_ok = (sx_d >= GAP_PX) && (sy_q >= GAP_PX);
`else
    assign gap_ok = 1'b1;
`endif

    assign inside0 = de_in && (col_d < COL_OUT) && (row_q < ROW_OUT) && gap_ok;
    assign addr0   = row_base_q + ADDR_W'(col_d);

    // ------------------------------------------------------------------
    // Stages 1..3: RAM read, RAM data, colour-stage outputs
    // ------------------------------------------------------------------
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              ins1_q, ins2_q, ins3_q;
    logic [2:0]        type3_q, type3_d;
    logic [2:0]        sync1_q, sync2_q, sync3_q;   // {de, hs, vs}

    // Address only moves on a real read so the RAM bus stays quiet otherwise.
    assign rd_addr_d = inside0 ? addr0 : rd_addr_q;
    assign type3_d   = ins2_q ? rd_data : 3'd0;

    // NOTE: the whole pipeline is reset so a mid-frame reset leaves no stale
    // read or inside flag in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            ins1_q    <= 1'b0;
            ins2_q    <= 1'b0;
            ins3_q    <= 1'b0;
            type3_q   <= 3'd0;
            sync1_q   <= 3'd0;
            sync2_q   <= 3'd0;
            sync3_q   <= 3'd0;
        end else begin
            rd_en_q   <= inside0;
            rd_addr_q <= rd_addr_d;
            ins1_q    <= inside0;
            ins2_q    <= ins1_q;
            ins3_q    <= ins2_q;
            type3_q   <= type3_d;
            sync1_q   <= {de_in, hs_in, vs_in};
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
        end
    end

    assign rd_en             = rd_en_q;
    assign rd_addr           = rd_addr_q;
    assign grid_point_inside = ins3_q;
    assign grid_cell_type    = type3_q;
    assign de_out            = sync3_q[2];
    assign hs_out            = sync3_q[1];
    assign vs_out            = sync3_q[0];

endmodule

// File: tb/tb_grid_cell_fetch.sv
// -----------------------------------------------------------------------------
// tb_grid_cell_fetch
//
// Drives a compressed raster (every line is present so row counting is exact,
// but lines away from the points of interest carry a single off-grid pixel).
// Expected values come from a direct arithmetic reference (division/modulo of
// the pixel position), pushed into queues when the pixel is driven; a monitor
// on the falling clock edge pops and compares when each entry falls due.
// -----------------------------------------------------------------------------
module tb_grid_cell_fetch;

  localparam int COORD_W = 11;
  localparam int ADDR_W  = 9;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               de_in, hs_in, vs_in;
  logic [COORD_W-1:0] px, py;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [2:0]         rd_data;
  logic               grid_point_inside;
  logic [2:0]         grid_cell_type;
  logic               de_out, hs_out, vs_out;

  always #5 clk = ~clk;

  grid_cell_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .de_in             (de_in),
    .hs_in             (hs_in),
    .vs_in             (vs_in),
    .px                (px),
    .py                (py),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .grid_point_inside (grid_point_inside),
    .grid_cell_type    (grid_cell_type),
    .de_out            (de_out),
    .hs_out            (hs_out),
    .vs_out            (vs_out)
  );

  // Board RAM: synchronous read, data one cycle after the strobe.
  logic [2:0] mem [0:511];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         due;
    int         x, y;
    logic       ins;
    logic [2:0] typ;
    logic [2:0] sync;
  } out_exp_t;

  typedef struct {
    int         due;
    int         x, y;
    logic       en;
    logic [8:0] addr;
  } rd_exp_t;

  out_exp_t oq[$];
  rd_exp_t  rq[$];

  // Reference state: what the bench knows about the raster so far.
  bit m_col_valid = 0;  // px==160 seen on this active run
  bit m_row_valid = 0;  // line 39 ended since last vsync / reset
  bit m_prev_de   = 0;
  bit m_prev_vs   = 0;
  int m_prev_py   = 0;
  bit in_reset    = 1;
  bit full_line [0:511];

  // Apply one pixel clock of inputs and queue the expected responses.
  task automatic tick(input logic de, input logic hs, input logic vs, input int x, input int y);
    bit       ins;
    int       addr;
    out_exp_t oe;
    rd_exp_t  re;
    de_in = de; hs_in = hs; vs_in = vs;
    px = 11'(x); py = 11'(y);
    if (in_reset) begin
      m_col_valid = 0; m_row_valid = 0; m_prev_de = 0; m_prev_vs = 0;
    end else begin
      if (vs && !m_prev_vs) m_row_valid = 0;
      else if (m_prev_de && !de && m_prev_py == 39) m_row_valid = 1;
      if (!de) m_col_valid = 0;
      else if (x == 160) m_col_valid = 1;
      ins = de && m_col_valid && x >= 160 && x < 480 && m_row_valid && y >= 40 && y < 440;
`ifdef GRID_GAP_EN
      ins = ins && ((x - 160) % 16) >= 1 && ((y - 40) % 16) >= 1;
`endif
      addr = ins ? ((y - 40) / 16) * 20 + (x - 160) / 16 : 0;
      oe.due = cyc + 3; oe.x = x; oe.y = y; oe.ins = ins;
      oe.typ = ins ? mem[addr] : 3'd0;
      oe.sync = {de, hs, vs};
      oq.push_back(oe);
      re.due = cyc + 1; re.x = x; re.y = y; re.en = ins; re.addr = 9'(addr);
      rq.push_back(re);
      m_prev_de = de; m_prev_vs = vs;
      if (de) m_prev_py = y;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever falls due on this cycle.
  out_exp_t mon_o;
  rd_exp_t  mon_r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        mon_r = rq.pop_front();
        check($sformatf("rd_en y%0d x%0d", mon_r.y, mon_r.x), rd_en, mon_r.en);
        if (mon_r.en)
          check($sformatf("rd_addr y%0d x%0d", mon_r.y, mon_r.x), rd_addr, mon_r.addr);
      end
      if (oq.size() > 0 && oq[0].due == cyc) begin
        mon_o = oq.pop_front();
        check($sformatf("inside y%0d x%0d", mon_o.y, mon_o.x), grid_point_inside, mon_o.ins);
        check($sformatf("type y%0d x%0d", mon_o.y, mon_o.x), grid_cell_type, mon_o.typ);
        check($sformatf("de/hs/vs y%0d x%0d", mon_o.y, mon_o.x),
              {de_out, hs_out, vs_out}, mon_o.sync);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"},    rd_en, 0);
    check({tag, " rd_addr"},  rd_addr, 0);
    check({tag, " inside"},   grid_point_inside, 0);
    check({tag, " type"},     grid_cell_type, 0);
    check({tag, " de_out"},   de_out, 0);
    check({tag, " hs_out"},   hs_out, 0);
    check({tag, " vs_out"},   vs_out, 0);
  endtask

  task automatic drive_line(input int y, input bit rand_hs);
    if (full_line[y]) begin
      for (int x = 150; x <= 490; x++)
        tick(1'b1, rand_hs ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, x, y);
    end else begin
      tick(1'b1, 1'b0, 1'b0, 0, y);
    end
    tick(1'b0, 1'b1, 1'b0, 0, y);
    tick(1'b0, 1'b0, 1'b0, 0, y);
  endtask

  task automatic vsync();
    tick(1'b0, 1'b0, 1'b1, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_full();
    for (int i = 0; i < 512; i++) full_line[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int guard;
    rst_n = 1'b0; in_reset = 1;
    de_in = 0; hs_in = 0; vs_in = 0; px = '0; py = '0;
    for (int i = 0; i < 512; i++) mem[i] = 3'd0;
    mem[0] = 3'd1; mem[1] = 3'd2; mem[19] = 3'd4; mem[20] = 3'd3;
    mem[480] = 3'd6; mem[499] = 3'd7;
    clear_full();

    // Reset state.
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_reset = 0;

    // Frame A: first pixel, cell boundaries, row change, last cell.
    full_line[40] = 1; full_line[41] = 1; full_line[55] = 1;
    full_line[56] = 1; full_line[439] = 1; full_line[440] = 1;
    vsync();
    for (int y = 0; y <= 441; y++) drive_line(y, 1'b0);

    // Frame B: reset in the middle of line 100.
    clear_full();
    full_line[120] = 1; full_line[300] = 1;
    vsync();
    for (int y = 0; y <= 99; y++) drive_line(y, 1'b0);
    for (int x = 150; x <= 300; x++) tick(1'b1, 1'b0, 1'b0, x, 100);
    #1;
    rst_n = 1'b0; in_reset = 1;
    oq.delete(); rq.delete();
    #1;
    check_all_zero("mid-frame reset");
    for (int x = 301; x <= 303; x++) tick(1'b1, 1'b0, 1'b0, x, 100);
    #1;
    rst_n = 1'b1; in_reset = 0;
    for (int x = 304; x <= 490; x++) tick(1'b1, 1'b0, 1'b0, x, 100);
    tick(1'b0, 1'b1, 1'b0, 0, 100);
    tick(1'b0, 1'b0, 1'b0, 0, 100);
    for (int y = 101; y <= 441; y++) drive_line(y, 1'b0);

    // Frame C: recovery after vsync, pseudo-random board, random hsync.
    for (int i = 0; i < 512; i++) mem[i] = 3'($urandom_range(0, 7));
    clear_full();
    full_line[39] = 1; full_line[40] = 1; full_line[47] = 1; full_line[100] = 1;
    full_line[200] = 1; full_line[255] = 1; full_line[256] = 1;
    full_line[439] = 1; full_line[440] = 1;
    vsync();
    for (int y = 0; y <= 441; y++) drive_line(y, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 0, 0);

    guard = 0;
    while ((oq.size() > 0 || rq.size() > 0) && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("pending expectations", oq.size() + rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
